cpu_bus_timer: RTL

Memory-mapped interval timer that sits on the cpu6502 external bus as a slave, next to the ROM/RAM models. The CPU initiates every transfer; this block decodes an 8-byte window, returns read data, commits writes, and raises `irq` toward the CPU when its 16-bit down-counter underflows. It gives the test programs a real interrupt source for exercising the CPU's IRQ, RTI and stack paths.

---
 rtl/cpu_bus_timer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/cpu_bus_timer.sv
// Memory-mapped 16-bit interval timer for the cpu6502 bus, with an IRQ raised on underflow.
// Define CPU_BUS_TIMER_PRESCALE_EN to add the PRE register at offset 6 and its prescaler.
module cpu_bus_timer #(
    parameter logic [15:0] BASE = 16'hD000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    input  logic        rw,
    input  logic        clk2,
    output logic [7:0]  rdata,
    output logic        sel,
    output logic        irq
);

    logic        clk2_q;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] latch_q, latch_d;
    logic        en_q, en_d;
    logic        cont_q, cont_d;
    logic        ie_q, ie_d;
    logic        if_q, if_d;
    logic        rise, fall, wr, rd, tick, uf;
`ifdef CPU_BUS_TIMER_PRESCALE_EN
    logic [7:0]  pre_q, pre_d;
    logic [7:0]  pcnt_q, pcnt_d;
`endif

    assign sel  = (addr[15:3] == BASE[15:3]);
    assign rise = clk2 & ~clk2_q;
    assign fall = ~clk2 & clk2_q;
    assign wr   = rise & sel & ~rw;
    assign rd   = fall & sel & rw;
    assign irq  = if_q & ie_q;

    always_comb begin
        rdata = 8'h00;
        if (sel) begin
            case (addr[2:0])
                3'd0: rdata = cnt_q[7:0];
                3'd1: rdata = cnt_q[15:8];
                3'd2: rdata = latch_q[7:0];
                3'd3: rdata = latch_q[15:8];
                3'd4: rdata = {ie_q, 5'b0, cont_q, en_q};
                3'd5: rdata = {7'b0, if_q};
`ifdef CPU_BUS_TIMER_PRESCALE_EN
                3'd6: rdata = pre_q;
`endif
                default: rdata = 8'h00;
            endcase
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        latch_d = latch_q;
        en_d    = en_q;
        cont_d  = cont_q;
        ie_d    = ie_q;
        if_d    = if_q;
        uf      = 1'b0;
`ifdef CPU_BUS_TIMER_PRESCALE_EN
        pre_d   = pre_q;
        pcnt_d  = pcnt_q;
        tick    = fall & en_q & (pcnt_q == pre_q);
        if (fall && en_q)
            pcnt_d = tick ? 8'h00 : pcnt_q + 8'h01;
`else
        tick    = fall & en_q;
`endif

        if (tick) begin
            if (cnt_q != 16'h0000) begin
                cnt_d = cnt_q - 16'h0001;
            end else begin
                uf = 1'b1;
                if (cont_q) cnt_d = latch_q;
                else        en_d  = 1'b0;
            end
        end

        if (rd && addr[2:0] == 3'd0)
            if_d = 1'b0;

        // Writes land after the count step so they override it; IF clears must precede the underflow set.
        if (wr) begin
            case (addr[2:0])
                3'd0: latch_d[7:0] = wdata;
                3'd1: begin
                    latch_d[15:8] = wdata;
                    cnt_d         = {wdata, latch_q[7:0]};
                    en_d          = 1'b1;
`ifdef CPU_BUS_TIMER_PRESCALE_EN
                    pcnt_d        = 8'h00;
`endif
                end
                3'd2: latch_d[7:0]  = wdata;
                3'd3: latch_d[15:8] = wdata;
                3'd4: begin
                    en_d   = wdata[0];
                    cont_d = wdata[1];
                    ie_d   = wdata[7];
                end
                3'd5: if (wdata[0]) if_d = 1'b0;
`ifdef CPU_BUS_TIMER_PRESCALE_EN
                3'd6: begin
                    pre_d  = wdata;
                    pcnt_d = 8'h00;
                end
`endif
                default: ;
            endcase
        end

        if (uf)
            if_d = 1'b1;
        if (wr && addr[2:0] == 3'd1)
            if_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk2_q  <= 1'b0;
            cnt_q   <= 16'h0000;
            latch_q <= 16'h0000;
            en_q    <= 1'b0;
            cont_q  <= 1'b0;
            ie_q    <= 1'b0;
            if_q    <= 1'b0;
`ifdef CPU_BUS_TIMER_PRESCALE_EN
            pre_q   <= 8'h00;
            pcnt_q  <= 8'h00;
`endif
        end else begin
            clk2_q  <= clk2;
            cnt_q   <= cnt_d;
            latch_q <= latch_d;
            en_q    <= en_d;
            cont_q  <= cont_d;
            ie_q    <= ie_d;
            if_q    <= if_d;
`ifdef CPU_BUS_TIMER_PRESCALE_EN
            pre_q   <= pre_d;
            pcnt_q  <= pcnt_d;
`endif
        end
    end

endmodule
